bcd_serial_adder: RTL and testbench

Digit-serial multi-digit BCD adder controller that sits directly upstream of the single-digit bcd_adder and drives it. It accepts two packed DIGITS-wide BCD operands through a start/busy/done handshake. It feeds one digit pair per clock, least-significant digit (LSD) first, into a bcd_adder instance, and ripples the carry through a register. The assembled multi-digit sum, the final carry and an invalid-digit error flag are registered outputs.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_adder.sv | 19 +
 rtl/bcd_serial_adder.sv | 118 +++++++++++
 tb/tb_bcd_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, controller state encoding and a
// digit-validity helper used by the serial adder.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_adder.sv
// Single-digit BCD adder: a + b + cin, producing a decimal digit and carry.
module bcd_adder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] raw;

    // Maximum raw value is 9+9+1=19, so one conditional subtract of ten suffices.
    assign raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    assign cout = (raw >= 5'd10);
    assign sum  = cout ? BCD_W'(raw - 5'd10) : raw[BCD_W-1:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: feeds one digit pair per clock, LSD
// first, into a bcd_adder and ripples the carry through a register.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] op_a,
    input  logic [BCD_W*DIGITS-1:0] op_b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t              state, state_nx;
    logic [W-1:0]        a_q, b_q;
    logic                carry;
    logic [IW-1:0]       idx;
    logic                ops_ok;
    logic [BCD_W-1:0]    a_dig, b_dig, ad_sum;
    logic                ad_cout;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(op_a[i*BCD_W +: BCD_W]) || !is_bcd(op_b[i*BCD_W +: BCD_W]))
                ops_ok = 1'b0;
        end
    end

    // Digit select from the latched operands; idx never leaves 0..DIGITS-1.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_q[i*BCD_W +: BCD_W];
                b_dig = b_q[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_adder u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry),
        .sum  (ad_sum),
        .cout (ad_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ops_ok ? ADD : DONE;
            ADD:     if (idx == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= !ops_ok;
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) sum[i*BCD_W +: BCD_W] <= ad_sum;
                    end
                    carry <= ad_cout;
                    if (idx == LAST) begin
                        cout <= ad_cout;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: a driver queues decimal-arithmetic
// expectations, a monitor checks each done pulse against them.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           k;      // index of the start edge
        int           lat;    // edges after the start edge until DONE is entered
        int           nbusy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   nchk = 0;
    int   nerr = 0;
    int   bcnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: convert operands to decimal integers, add, convert back.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int k);
        exp_t   e;
        longint av = 0, bv = 0, p = 1, t;
        bit     bad = 0;
        for (int i = D - 1; i >= 0; i--) begin
            int da = int'(a[4*i +: 4]);
            int db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) bad = 1;
            av = av * 10 + da;
            bv = bv * 10 + db;
            p  = p * 10;
        end
        e.k = k;
        e.sum = '0;
        if (bad) begin
            e.cout = 1'b0; e.err = 1'b1; e.lat = 0; e.nbusy = 0;
        end else begin
            t = av + bv + longint'(c);
            e.cout = (t >= p);
            t = t % p;
            for (int i = 0; i < D; i++) begin
                e.sum[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            e.err = 1'b0; e.lat = D; e.nbusy = D;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v = '0;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_done: got done=1 required no pending transaction");
                end else begin
                    m_e = q.pop_front();
                    check("sum", longint'(sum), longint'(m_e.sum));
                    check("cout", longint'(cout), longint'(m_e.cout));
                    check("err", longint'(err), longint'(m_e.err));
                    check("latency", longint'(cyc - m_e.k), longint'(m_e.lat));
                    check("busy_cycles", longint'(bcnt), longint'(m_e.nbusy));
                end
                bcnt = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit track);
        int guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            nchk++; nerr++;
            $display("FAIL idle_wait: got busy=%0b done=%0b required idle", busy, done);
        end
        op_a = a; op_b = b; cin = c; start = 1'b1;
        if (track) q.push_back(model(a, b, c, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_sum"},  longint'(sum),  0);
        check({tag, "_cout"}, longint'(cout), 0);
        check({tag, "_err"},  longint'(err),  0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int g;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        issue(16'h1234, 16'h5678, 1'b0, 1'b1);
        issue(16'h9999, 16'h0001, 1'b0, 1'b1);
        issue(16'h9999, 16'h9999, 1'b1, 1'b1);
        issue(16'h12A4, 16'h0000, 1'b0, 1'b1);
        issue(16'h0042, 16'h0017, 1'b1, 1'b1);

        // Restarts during ADD and DONE must be ignored.
        issue(16'h2345, 16'h1111, 1'b0, 1'b1);
        op_a = 16'h8888; op_b = 16'h7777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!done && g < 20) begin @(negedge clk); g++; end
        op_a = 16'h4444; op_b = 16'h3333; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in the second ADD cycle discards the transaction.
        issue(16'h0005, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0005, 16'h0005, 1'b0, 1'b1);

        for (int n = 0; n < 20; n++) issue(rand_bcd(), rand_bcd(), 1'($urandom), 1'b1);
        for (int n = 0; n < 5; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if (n % 2 == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            else            rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            issue(ra, rb, 1'($urandom), 1'b1);
            issue(rand_bcd(), rand_bcd(), 1'($urandom), 1'b1);
        end

        g = 0;
        while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        if (q.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
